iopmp_axil_cfg_bridge: RTL and testbench
========================================

Name: iopmp_axil_cfg_bridge

Overview:
- AXI4-Lite subordinate (slave) that turns AXI4-Lite reads and writes into single-cycle accesses on the IOPMP register-configuration port: address_cfg, en_cfg, we_cfg, wdata_cfg, rdata_cfg.
- Acts as the initiator on the configuration port, which the iopmp block serves as responder.
- Sits between the SoC AXI4-Lite interconnect and the iopmp instance; one access is outstanding at a time.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI4-Lite and address_cfg address width.
- AXI_DATA_WIDTH, 64, AXI4-Lite and configuration-port data width; must be 64.
- BASE_ADDR, 64'h5000_0000, first byte of the IOPMP register window.
- WINDOW_BYTES, 64'h1000, window size in bytes; addresses outside [BASE_ADDR, BASE_ADDR+WINDOW_BYTES) decode to an error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- s_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_awvalid  in  1 / s_awready  out  1  AW handshake.
- s_wdata  in  64  write data.
- s_wstrb  in  8  write byte strobes.
- s_wvalid  in  1 / s_wready  out  1  W handshake.
- s_bresp  out  2 / s_bvalid  out  1 / s_bready  in  1  B channel.
- s_araddr  in  AXI_ADDR_WIDTH / s_arvalid  in  1 / s_arready  out  1  AR channel.
- s_rdata  out  64 / s_rresp  out  2 / s_rvalid  out  1 / s_rready  in  1  R channel.
- address_cfg  out  AXI_ADDR_WIDTH  full byte address, BASE_ADDR included.
- en_cfg  out  1  access strobe.
- we_cfg  out  1  1 = write.
- wdata_cfg  out  64  right-aligned write data.
- rdata_cfg  in  64  combinational read data, valid while en_cfg=1 and we_cfg=0.

Behaviour:
- Reset (async, active-high): FSM to IDLE; AW/W holding buffers empty; round-robin flag = write-first.
  - en_cfg=0, we_cfg=0, address_cfg=0, wdata_cfg=0.
  - s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0.
  - s_awready=1, s_wready=1, s_arready=0.
- Reset mid-operation: the transaction is dropped with no response, and en_cfg falls immediately.
- AW and W are captured independently, in any order, into one-entry holding buffers. s_awready = AW buffer empty; s_wready = W buffer empty.
- FSM states: IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP.
- Write is pending when both buffers are full. Read is pending when s_arvalid=1.
- IDLE arbitration:
  - Only write pending -> WR_ACC.
  - Only read pending -> s_arready=1; on the handshake, latch araddr -> RD_ACC.
  - Both pending -> round-robin flag decides; the flag toggles after each grant.
  - s_arready is asserted only in IDLE when read is granted.
- WR_ACC (exactly 1 cycle):
  - address_cfg = awaddr; wdata_cfg = wdata >> (8*awaddr[2:0]).
  - en_cfg=1 and we_cfg=1, but only if the address is in the window and wstrb != 0.
  - Both buffers are cleared, so the next AW/W may be captured during WR_RESP.
  - Next state: WR_RESP.
- WR_RESP: s_bvalid=1 held until s_bready; then IDLE.
  - s_bresp = 2'b11 (DECERR) if out of window, else 2'b00 (OKAY).
  - wstrb == 0 performs no write and returns OKAY.
- RD_ACC (1 cycle):
  - If in window: en_cfg=1, we_cfg=0, address_cfg = araddr.
  - Sample s_rdata = rdata_cfg << (8*araddr[2:0]), truncated to 64 bits.
  - Out of window: no strobe; s_rdata=0, s_rresp=2'b11.
- RD_RESP: s_rvalid=1 with s_rdata/s_rresp stable until s_rready; then IDLE.
- Latency:
  - AR handshake at cycle N: en_cfg at N+1, s_rvalid at N+2.
  - Second of AW/W accepted at cycle N: en_cfg at N+2 (one IDLE cycle), s_bvalid at N+3.
- en_cfg is never high for more than one consecutive cycle per access, except under the optional feature below.
- Window check: (addr - BASE_ADDR) < WINDOW_BYTES, computed unsigned at AXI_ADDR_WIDTH+1 bits, so an address below BASE_ADDR wraps and fails.

Optional Feature:
- Macro: IOPMP_CFG_RDATA_PIPE_EN.
- Defined: extra state RD_WAIT is inserted between RD_ACC and RD_RESP.
  - en_cfg and address_cfg are held for 2 cycles.
  - rdata_cfg is sampled in the second cycle, supporting a registered-read register file.
  - Read latency becomes N+3.
- Undefined: no RD_WAIT; behaviour as above.

Decomposition:
- iopmp_pkg gains:
  - enum iopmp_cfg_bridge_state_t;
  - constants AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
- Register offsets continue to come from iopmp_pkg (IOPMP_CTL_OFF, IOPMP_RCD_OFF, ...).
- No sub-module: arbitration is a single flag, and the holding buffers are two flops each.

Test Plan:
- Write to BASE_ADDR+IOPMP_CTL_OFF, wdata 32'hC000_0001, wstrb 8'hFF, AW before W -> one-cycle en_cfg=1/we_cfg=1 with wdata_cfg=64'hC000_0001; bresp=OKAY; then read back 32'hC000_0001.
- Byte write to BASE_ADDR+IOPMP_ENTRY_CFG_OFF+1, wdata 64'h0000_0000_0000_9E00, wstrb 8'h02, W before AW -> wdata_cfg=64'h9E, address_cfg = BASE+IOPMP_ENTRY_CFG_OFF+1.
- Read 0x4000_0000 and write 0x5000_1000 -> no en_cfg; rresp=DECERR with rdata=0; bresp=DECERR.
- AR and AW+W presented in the same cycle, back-to-back twice -> write, read, write, read grant order after reset; each access yields exactly one en_cfg pulse.
- s_rready held low 5 cycles -> s_rvalid and s_rdata stable; no new en_cfg; a new AW is accepted but not issued until RD_RESP completes.
- rst_i asserted during WR_RESP -> bvalid drops asynchronously; the next write after release completes with OKAY.

Source files
------------

// File: rtl/iopmp_pkg.sv
// Shared IOPMP definitions: register offsets, AXI response codes and the cfg-bridge FSM states.
package iopmp_pkg;

  localparam logic [31:0] IOPMP_VERSION_OFF        = 32'h0000_0000;
  localparam logic [31:0] IOPMP_IMPLEMENTATION_OFF = 32'h0000_0004;
  localparam logic [31:0] IOPMP_CTL_OFF            = 32'h0000_0008;
  localparam logic [31:0] IOPMP_RCD_OFF            = 32'h0000_0010;
  localparam logic [31:0] IOPMP_ERR_INFO_OFF       = 32'h0000_0018;
  localparam logic [31:0] IOPMP_ENTRY_ADDR_OFF     = 32'h0000_0800;
  localparam logic [31:0] IOPMP_ENTRY_CFG_OFF      = 32'h0000_0808;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    CFG_IDLE,
    CFG_WR_ACC,
    CFG_WR_RESP,
    CFG_RD_ACC,
    CFG_RD_WAIT,
    CFG_RD_RESP
  } iopmp_cfg_bridge_state_t;

endpackage

// File: rtl/iopmp_axil_cfg_bridge.sv
// AXI4-Lite subordinate driving the IOPMP single-cycle register-configuration port.
// Optional macro IOPMP_CFG_RDATA_PIPE_EN adds a wait state for a registered-read register file.
module iopmp_axil_cfg_bridge
  import iopmp_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR      = 64'h5000_0000,
  parameter logic [63:0] WINDOW_BYTES   = 64'h1000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic [AXI_ADDR_WIDTH-1:0]   address_cfg,
  output logic                        en_cfg,
  output logic                        we_cfg,
  output logic [AXI_DATA_WIDTH-1:0]   wdata_cfg,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata_cfg
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH:0] BASE_EXT = (AXI_ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [AXI_ADDR_WIDTH:0] WIN_EXT  = (AXI_ADDR_WIDTH+1)'(WINDOW_BYTES);

  // One extra bit so an address below the base wraps to a huge offset and misses.
  function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH:0] offset;
    offset = {1'b0, addr} - BASE_EXT;
    return offset < WIN_EXT;
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] lane_to_lsb(input logic [AXI_DATA_WIDTH-1:0] data,
                                                            input logic [2:0] lane);
    return data >> {lane, 3'b000};
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] lsb_to_lane(input logic [AXI_DATA_WIDTH-1:0] data,
                                                            input logic [2:0] lane);
    return data << {lane, 3'b000};
  endfunction

  iopmp_cfg_bridge_state_t state_q, state_d;

  logic                      aw_full_q, w_full_q, wr_first_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, rdata_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic [1:0]                bresp_q, rresp_q;
  logic                      wr_pend, rd_pend, grant_wr, grant_rd;
  logic                      wr_hit, rd_hit, rd_sample;

  assign wr_pend   = aw_full_q & w_full_q;
  assign rd_pend   = s_arvalid;
  assign wr_hit    = in_window(aw_addr_q);
  assign rd_hit    = in_window(ar_addr_q);

  assign s_awready = ~aw_full_q;
  assign s_wready  = ~w_full_q;
  assign s_bvalid  = (state_q == CFG_WR_RESP);
  assign s_rvalid  = (state_q == CFG_RD_RESP);
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CFG_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      wr_first_q <= 1'b1;
      bresp_q    <= AXI_RESP_OKAY;
      rresp_q    <= AXI_RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_wr || grant_rd) wr_first_q <= ~wr_first_q;
      // Buffers free up as the write issues, so the next AW/W can land during WR_RESP.
      if (state_q == CFG_WR_ACC) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bresp_q   <= wr_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
      end else begin
        if (s_awvalid && !aw_full_q) aw_full_q <= 1'b1;
        if (s_wvalid && !w_full_q)   w_full_q  <= 1'b1;
      end
      if (rd_sample) begin
        rdata_q <= rd_hit ? lsb_to_lane(rdata_cfg, ar_addr_q[2:0]) : '0;
        rresp_q <= rd_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (s_awvalid && !aw_full_q) aw_addr_q <= s_awaddr;
    if (s_wvalid && !w_full_q) begin
      w_data_q <= s_wdata;
      w_strb_q <= s_wstrb;
    end
    if (grant_rd) ar_addr_q <= s_araddr;
  end

  always_comb begin
    state_d     = state_q;
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    rd_sample   = 1'b0;
    s_arready   = 1'b0;
    en_cfg      = 1'b0;
    we_cfg      = 1'b0;
    address_cfg = '0;
    wdata_cfg   = '0;
    case (state_q)
      CFG_IDLE: begin
        if (wr_pend && (!rd_pend || wr_first_q)) begin
          grant_wr = 1'b1;
          state_d  = CFG_WR_ACC;
        end else if (rd_pend) begin
          grant_rd  = 1'b1;
          s_arready = 1'b1;
          state_d   = CFG_RD_ACC;
        end
      end
      CFG_WR_ACC: begin
        address_cfg = aw_addr_q;
        wdata_cfg   = lane_to_lsb(w_data_q, aw_addr_q[2:0]);
        en_cfg      = wr_hit && (w_strb_q != '0);
        we_cfg      = en_cfg;
        state_d     = CFG_WR_RESP;
      end
      CFG_WR_RESP: if (s_bready) state_d = CFG_IDLE;
      CFG_RD_ACC: begin
        en_cfg      = rd_hit;
        address_cfg = rd_hit ? ar_addr_q : '0;
`ifdef IOPMP_CFG_RDATA_PIPE_EN
        state_d     = CFG_RD_WAIT;
`else
        rd_sample   = 1'b1;
        state_d     = CFG_RD_RESP;
`endif
      end
`ifdef IOPMP_CFG_RDATA_PIPE_EN
      CFG_RD_WAIT: begin
        en_cfg      = rd_hit;
        address_cfg = rd_hit ? ar_addr_q : '0;
        rd_sample   = 1'b1;
        state_d     = CFG_RD_RESP;
      end
`endif
      CFG_RD_RESP: if (s_rready) state_d = CFG_IDLE;
      default: state_d = CFG_IDLE;
    endcase
  end

endmodule

// File: tb/tb_iopmp_axil_cfg_bridge.sv
// Directed bench for iopmp_axil_cfg_bridge with a small register-file responder on the cfg port.
module tb_iopmp_axil_cfg_bridge;
  import iopmp_pkg::*;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clk_i, rst_i;
  logic [31:0] s_awaddr, s_araddr, address_cfg;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [63:0] s_wdata, s_rdata, wdata_cfg, rdata_cfg;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        en_cfg, we_cfg;

  int n_cmp = 0;
  int n_bad = 0;

  iopmp_axil_cfg_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .address_cfg(address_cfg), .en_cfg(en_cfg), .we_cfg(we_cfg),
    .wdata_cfg(wdata_cfg), .rdata_cfg(rdata_cfg)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Responder: one 64-bit word per 8-byte slot, data stored right-aligned as delivered.
  logic [63:0] mem [0:511];
  assign rdata_cfg = mem[address_cfg[11:3]];
  always @(posedge clk_i) if (en_cfg && we_cfg) mem[address_cfg[11:3]] <= wdata_cfg;

  int          en_cnt  = 0;
  int          dbl_cnt = 0;
  logic        en_prev = 1'b0;
  logic        log_we[$];
  logic [31:0] log_addr[$];
  logic [63:0] log_wdata[$];

  always @(negedge clk_i) begin
    if (rst_i) en_prev <= 1'b0;
    else begin
      if (en_cfg && !en_prev) begin
        en_cnt <= en_cnt + 1;
        log_we.push_back(we_cfg);
        log_addr.push_back(address_cfg);
        log_wdata.push_back(wdata_cfg);
      end
`ifdef IOPMP_CFG_RDATA_PIPE_EN
      if (en_cfg && en_prev && we_cfg) dbl_cnt <= dbl_cnt + 1;
`else
      if (en_cfg && en_prev) dbl_cnt <= dbl_cnt + 1;
`endif
      en_prev <= en_cfg;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic timeout(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout_%s: handshake not seen, required within 50 cycles", what);
  endtask

  task automatic send_aw(input logic [31:0] a);
    s_awaddr  = a;
    s_awvalid = 1'b1;
    for (int i = 0; i < 50 && !s_awready; i++) tick();
    if (!s_awready) timeout("aw");
    tick();
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    s_wdata  = d;
    s_wstrb  = s;
    s_wvalid = 1'b1;
    for (int i = 0; i < 50 && !s_wready; i++) tick();
    if (!s_wready) timeout("w");
    tick();
    s_wvalid = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] r);
    s_bready = 1'b1;
    for (int i = 0; i < 50 && !s_bvalid; i++) tick();
    if (!s_bvalid) begin
      timeout("b");
      r = 2'bxx;
    end else r = s_bresp;
    tick();
    s_bready = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    s_araddr  = a;
    s_arvalid = 1'b1;
    #1;
    for (int i = 0; i < 50 && !s_arready; i++) tick();
    if (!s_arready) timeout("ar");
    tick();
    s_arvalid = 1'b0;
  endtask

  task automatic get_r(output logic [63:0] d, output logic [1:0] r);
    s_rready = 1'b1;
    for (int i = 0; i < 50 && !s_rvalid; i++) tick();
    if (!s_rvalid) begin
      timeout("r");
      d = 'x;
      r = 2'bxx;
    end else begin
      d = s_rdata;
      r = s_rresp;
    end
    tick();
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({en_cfg, we_cfg} !== 2'b00) begin n_bad++; $display("FAIL reset_strobe: en/we=%b required 00", {en_cfg, we_cfg}); end
    n_cmp++; if (address_cfg !== 32'h0 || wdata_cfg !== 64'h0) begin n_bad++; $display("FAIL reset_cfg_bus: addr=%h wdata=%h required 0/0", address_cfg, wdata_cfg); end
    n_cmp++; if ({s_bvalid, s_rvalid, s_bresp, s_rresp} !== 6'b0) begin n_bad++; $display("FAIL reset_resp: bv/rv/bresp/rresp=%b required 000000", {s_bvalid, s_rvalid, s_bresp, s_rresp}); end
    n_cmp++; if (s_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: %h required 0", s_rdata); end
    n_cmp++; if ({s_awready, s_wready, s_arready} !== 3'b110) begin n_bad++; $display("FAIL reset_ready: aw/w/ar=%b required 110", {s_awready, s_wready, s_arready}); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_ctl_write_read();
    logic [1:0]  r;
    logic [63:0] d;
    send_aw(BASE + IOPMP_CTL_OFF);
    send_w(64'h0000_0000_C000_0001, 8'hFF);
    n_cmp++; if (en_cfg !== 1'b0) begin n_bad++; $display("FAIL ctl_idle_gap: en=%b required 0", en_cfg); end
    tick();
    n_cmp++; if ({en_cfg, we_cfg} !== 2'b11 || address_cfg !== 32'h5000_0008 || wdata_cfg !== 64'hC000_0001) begin
      n_bad++; $display("FAIL ctl_wr_issue: en/we=%b addr=%h wdata=%h required 11/50000008/c0000001", {en_cfg, we_cfg}, address_cfg, wdata_cfg);
    end
    tick();
    n_cmp++; if (s_bvalid !== 1'b1 || en_cfg !== 1'b0) begin n_bad++; $display("FAIL ctl_bvalid_lat: bvalid=%b en=%b required 1/0", s_bvalid, en_cfg); end
    get_b(r);
    n_cmp++; if (r !== AXI_RESP_OKAY) begin n_bad++; $display("FAIL ctl_bresp: %b required 00", r); end
    send_ar(BASE + IOPMP_CTL_OFF);
    n_cmp++; if ({en_cfg, we_cfg} !== 2'b10 || address_cfg !== 32'h5000_0008) begin
      n_bad++; $display("FAIL ctl_rd_issue: en/we=%b addr=%h required 10/50000008", {en_cfg, we_cfg}, address_cfg);
    end
`ifdef IOPMP_CFG_RDATA_PIPE_EN
    tick();
`endif
    tick();
    n_cmp++; if (s_rvalid !== 1'b1) begin n_bad++; $display("FAIL ctl_rvalid_lat: rvalid=%b required 1", s_rvalid); end
    get_r(d, r);
    n_cmp++; if (d !== 64'hC000_0001 || r !== AXI_RESP_OKAY) begin n_bad++; $display("FAIL ctl_readback: rdata=%h rresp=%b required c0000001/00", d, r); end
  endtask

  task automatic test_byte_write();
    logic [1:0]  r;
    logic [63:0] d;
    int          c0;
    send_w(64'h0000_0000_0000_9E00, 8'h02);
    send_aw(BASE + IOPMP_ENTRY_CFG_OFF + 32'd1);
    tick();
    n_cmp++; if ({en_cfg, we_cfg} !== 2'b11 || address_cfg !== 32'h5000_0809 || wdata_cfg !== 64'h9E) begin
      n_bad++; $display("FAIL byte_wr_issue: en/we=%b addr=%h wdata=%h required 11/50000809/9e", {en_cfg, we_cfg}, address_cfg, wdata_cfg);
    end
    get_b(r);
    n_cmp++; if (r !== AXI_RESP_OKAY) begin n_bad++; $display("FAIL byte_bresp: %b required 00", r); end
    send_ar(BASE + IOPMP_ENTRY_CFG_OFF + 32'd1);
    get_r(d, r);
    n_cmp++; if (d !== 64'h9E00 || r !== AXI_RESP_OKAY) begin n_bad++; $display("FAIL byte_readback: rdata=%h rresp=%b required 9e00/00", d, r); end
    c0 = en_cnt;
    send_aw(BASE + 32'h40);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    get_b(r);
    n_cmp++; if (r !== AXI_RESP_OKAY || en_cnt !== c0) begin n_bad++; $display("FAIL zero_strb: bresp=%b pulses=%0d required 00/0", r, en_cnt - c0); end
  endtask

  task automatic test_decerr();
    logic [1:0]  r;
    logic [63:0] d;
    int          c0;
    c0 = en_cnt;
    send_ar(32'h4000_0000);
    get_r(d, r);
    n_cmp++; if (d !== 64'h0 || r !== AXI_RESP_DECERR) begin n_bad++; $display("FAIL below_base_read: rdata=%h rresp=%b required 0/11", d, r); end
    send_aw(32'h5000_1000);
    send_w(64'h1234, 8'hFF);
    get_b(r);
    n_cmp++; if (r !== AXI_RESP_DECERR) begin n_bad++; $display("FAIL past_end_write: bresp=%b required 11", r); end
    n_cmp++; if (en_cnt !== c0) begin n_bad++; $display("FAIL decerr_no_strobe: pulses=%0d required 0", en_cnt - c0); end
    send_aw(32'h5000_0FF8);
    send_w(64'h77, 8'hFF);
    get_b(r);
    n_cmp++; if (r !== AXI_RESP_OKAY || en_cnt !== c0 + 1) begin n_bad++; $display("FAIL last_word_write: bresp=%b pulses=%0d required 00/1", r, en_cnt - c0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa [2];
    logic [63:0] wd [2];
    logic [31:0] ra [2];
    logic [63:0] rd_got [2];
    logic [1:0]  b_got [2];
    logic [3:0]  seq;
    int aw_i, w_i, ar_i, b_n, r_n;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    log_we.delete(); log_addr.delete(); log_wdata.delete();
    wa[0] = BASE + 32'h20; wd[0] = 64'hA1; ra[0] = BASE + 32'h20;
    wa[1] = BASE + 32'h28; wd[1] = 64'hB2; ra[1] = BASE + 32'h28;
    aw_i = 0; w_i = 0; ar_i = 0; b_n = 0; r_n = 0;
    s_bready = 1'b1;
    s_rready = 1'b1;
    for (int cyc = 0; cyc < 60 && !(b_n == 2 && r_n == 2); cyc++) begin
      s_awvalid = (aw_i < 2);
      if (aw_i < 2) s_awaddr = wa[aw_i];
      s_wvalid = (w_i < 2);
      s_wstrb  = 8'hFF;
      if (w_i < 2) s_wdata = wd[w_i];
      s_arvalid = (cyc >= 1) && (ar_i < 2);
      if (ar_i < 2) s_araddr = ra[ar_i];
      #1;
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      ar_hs = s_arvalid && s_arready;
      b_hs  = s_bvalid;
      r_hs  = s_rvalid;
      if (b_hs && b_n < 2) b_got[b_n] = s_bresp;
      if (r_hs && r_n < 2) rd_got[r_n] = s_rdata;
      tick();
      if (aw_hs) aw_i++;
      if (w_hs)  w_i++;
      if (ar_hs) ar_i++;
      if (b_hs)  b_n++;
      if (r_hs)  r_n++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_bready = 1'b0; s_rready = 1'b0;
    if (b_n != 2 || r_n != 2) timeout("b2b");
    n_cmp++; if (log_we.size() !== 4) begin n_bad++; $display("FAIL b2b_pulse_count: %0d required 4", log_we.size()); end
    else begin
      for (int i = 0; i < 4; i++) seq[3-i] = log_we[i];
      n_cmp++; if (seq !== 4'b1010) begin n_bad++; $display("FAIL b2b_grant_order: we seq=%b required 1010", seq); end
      n_cmp++; if (log_addr[0] !== wa[0] || log_addr[1] !== ra[0] || log_addr[2] !== wa[1] || log_addr[3] !== ra[1]) begin
        n_bad++; $display("FAIL b2b_addr_order: %h %h %h %h required %h %h %h %h", log_addr[0], log_addr[1], log_addr[2], log_addr[3], wa[0], ra[0], wa[1], ra[1]);
      end
    end
    n_cmp++; if (rd_got[0] !== 64'hA1 || rd_got[1] !== 64'hB2) begin n_bad++; $display("FAIL b2b_rdata: %h %h required a1 b2", rd_got[0], rd_got[1]); end
    n_cmp++; if (b_got[0] !== AXI_RESP_OKAY || b_got[1] !== AXI_RESP_OKAY) begin n_bad++; $display("FAIL b2b_bresp: %b %b required 00 00", b_got[0], b_got[1]); end
  endtask

  task automatic test_rready_stall();
    logic [1:0] r;
    int         c0, bad;
    send_ar(BASE + 32'h28);
    tick();
    c0 = en_cnt;
    s_awaddr = BASE + 32'h30; s_awvalid = 1'b1;
    s_wdata = 64'hC3; s_wstrb = 8'hFF; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_rvalid !== 1'b1 || s_rdata !== 64'hB2) bad++;
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_r_stable: %0d unstable cycles, rdata=%h required 0/b2", bad, s_rdata); end
    n_cmp++; if ({s_awready, s_wready} !== 2'b00 || en_cnt !== c0) begin
      n_bad++; $display("FAIL stall_hold_write: aw/w ready=%b pulses=%0d required 00/0", {s_awready, s_wready}, en_cnt - c0);
    end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    tick();
    n_cmp++; if ({en_cfg, we_cfg} !== 2'b11 || address_cfg !== 32'h5000_0030 || wdata_cfg !== 64'hC3) begin
      n_bad++; $display("FAIL stall_wr_issue: en/we=%b addr=%h wdata=%h required 11/50000030/c3", {en_cfg, we_cfg}, address_cfg, wdata_cfg);
    end
    get_b(r);
    n_cmp++; if (r !== AXI_RESP_OKAY) begin n_bad++; $display("FAIL stall_bresp: %b required 00", r); end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  r;
    logic [63:0] d;
    send_aw(BASE + 32'h38);
    send_w(64'h55, 8'hFF);
    for (int i = 0; i < 10 && !s_bvalid; i++) tick();
    if (!s_bvalid) timeout("mid_bvalid");
    #2;
    rst_i = 1'b1;
    #1;
    n_cmp++; if ({s_bvalid, en_cfg, s_awready} !== 3'b001) begin
      n_bad++; $display("FAIL mid_reset_async: bvalid/en/awready=%b required 001", {s_bvalid, en_cfg, s_awready});
    end
    tick();
    rst_i = 1'b0;
    tick();
    send_aw(BASE + 32'h38);
    send_w(64'h66, 8'hFF);
    get_b(r);
    n_cmp++; if (r !== AXI_RESP_OKAY) begin n_bad++; $display("FAIL post_reset_bresp: %b required 00", r); end
    send_ar(BASE + 32'h38);
    get_r(d, r);
    n_cmp++; if (d !== 64'h66 || r !== AXI_RESP_OKAY) begin n_bad++; $display("FAIL post_reset_readback: rdata=%h rresp=%b required 66/00", d, r); end
  endtask

  initial begin
    rst_i = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    test_reset();
    test_ctl_write_read();
    test_byte_write();
    test_decerr();
    test_back_to_back();
    test_rready_stall();
    test_reset_mid();
    n_cmp++; if (dbl_cnt !== 0) begin n_bad++; $display("FAIL en_single_cycle: %0d multi-cycle strobes required 0", dbl_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
